hbridge_gate_sequencer: RTL and testbench

Sequences the full-bridge inverter of the active harmonic filter: it takes the 2-bit SPWM command from the sinusoidal PWM comparator and produces the four registered IGBT gate signals. It adds per-leg dead time, runs a bootstrap precharge before modulation and latches faults. The block sits between the SPWM comparator and the gate-driver pins and is the only path to the gates.

---
 rtl/hbridge_pkg.sv | 28 ++
 rtl/leg_deadtime.sv | 71 +++++++
 rtl/hbridge_gate_sequencer.sv | 155 +++++++++++++++
 tb/tb_hbridge_gate_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_pkg.sv
// rtl/hbridge_pkg.sv - shared types and constants for the H-bridge gate sequencer
package hbridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRECHARGE = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_EXT  = 2'b01;
  localparam logic [1:0] FLT_CMD  = 2'b10;

  localparam logic [1:0] CMD_ZERO = 2'b00;
  localparam logic [1:0] CMD_POS  = 2'b01;
  localparam logic [1:0] CMD_NEG  = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  localparam int GATE_A_HI = 3;
  localparam int GATE_A_LO = 2;
  localparam int GATE_B_HI = 1;
  localparam int GATE_B_LO = 0;

  localparam logic LEG_LO = 1'b0;
  localparam logic LEG_HI = 1'b1;

endpackage

// File: rtl/leg_deadtime.sv
// rtl/leg_deadtime.sv - one half-bridge leg with break-before-make dead time
// Ports: i_clk, i_rst_n (sync, active-low), i_kill (force LO/off),
//        i_target (LEG_HI/LEG_LO), i_deadtime (cycles, 0 acts as 1),
//        o_hi / o_lo (registered switch drives, never both 1).
module leg_deadtime
  import hbridge_pkg::*;
#(
  parameter int NB_DT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_kill,
  input  logic             i_target,
  input  logic [NB_DT-1:0] i_deadtime,
  output logic             o_hi,
  output logic             o_lo
);

  logic             target_q, target_d;
  logic [NB_DT-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;
  logic             lo_q, lo_d;
  logic [NB_DT-1:0] d_eff;

  always_comb begin
    d_eff    = (i_deadtime == '0) ? NB_DT'(1) : i_deadtime;
    target_d = target_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (i_kill) begin
      target_d = LEG_LO;
      cnt_d    = '0;
      hi_d     = 1'b0;
      lo_d     = 1'b0;
    end else if (i_target != target_q) begin
      // Any retarget, even mid dead time, restarts the full gap.
      target_d = i_target;
      cnt_d    = d_eff;
      hi_d     = 1'b0;
      lo_d     = 1'b0;
    end else if (cnt_q > NB_DT'(1)) begin
      cnt_d = cnt_q - NB_DT'(1);
      hi_d  = 1'b0;
      lo_d  = 1'b0;
    end else begin
      // Counter expiring (1 -> 0) switches on in the same edge.
      cnt_d = '0;
      hi_d  = (target_q == LEG_HI);
      lo_d  = (target_q == LEG_LO);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      target_q <= LEG_LO;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
    end else begin
      target_q <= target_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign o_hi = hi_q;
  assign o_lo = lo_q;

endmodule

// File: rtl/hbridge_gate_sequencer.sv
// rtl/hbridge_gate_sequencer.sv - full-bridge gate sequencer: precharge, dead time, fault latch
// Ports: i_clk, i_rst_n (sync, active-low), i_en, i_pwm (01 +Vdc, 10 -Vdc, 00 zero, 11 invalid),
//        i_fault_n (async, active-low), i_clr_fault, i_deadtime, i_precharge_cycles,
//        o_gate {A_hi, A_lo, B_hi, B_lo}, o_running, o_fault, o_fault_code.
module hbridge_gate_sequencer
  import hbridge_pkg::*;
#(
  parameter int NB_DT = 8,
  parameter int NB_PC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_pwm,
  input  logic             i_fault_n,
  input  logic             i_clr_fault,
  input  logic [NB_DT-1:0] i_deadtime,
  input  logic [NB_PC-1:0] i_precharge_cycles,
  output logic [3:0]       o_gate,
  output logic             o_running,
  output logic             o_fault,
  output logic [1:0]       o_fault_code
);

  state_e           state_q, state_d;
  logic [1:0]       pwm_q, pwm_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             bad_q, bad_d;
  logic [NB_PC-1:0] pc_cnt_q, pc_cnt_d;
  logic [1:0]       code_q, code_d;
  logic             tgt_a_q, tgt_a_d;
  logic             tgt_b_q, tgt_b_d;
  logic [NB_PC-1:0] p_eff;
  logic             ext_flt, cmd_flt, kill;
  logic             a_hi, a_lo, b_hi, b_lo;

  always_comb begin
    pwm_d    = i_pwm;
    sync1_d  = i_fault_n;
    sync2_d  = sync1_q;
    state_d  = state_q;
    pc_cnt_d = '0;
    code_d   = code_q;
    p_eff    = (i_precharge_cycles == '0) ? NB_PC'(1) : i_precharge_cycles;
    ext_flt  = !sync2_q;
    // bad_q remembers an invalid command seen in RUN on the previous cycle.
    bad_d    = (state_q == ST_RUN) && (pwm_q == CMD_BAD);
    cmd_flt  = bad_d && bad_q;

    if ((state_q != ST_FAULT) && (ext_flt || cmd_flt)) begin
      state_d = ST_FAULT;
      code_d  = ext_flt ? FLT_EXT : FLT_CMD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_en) begin
            state_d  = ST_PRECHARGE;
            pc_cnt_d = p_eff;
          end
        end
        ST_PRECHARGE: begin
          if (!i_en) state_d = ST_IDLE;
          else if (pc_cnt_q == NB_PC'(1)) state_d = ST_RUN;
          else pc_cnt_d = pc_cnt_q - NB_PC'(1);
        end
        ST_RUN: begin
          if (!i_en) state_d = ST_IDLE;
        end
        ST_FAULT: begin
          if (i_clr_fault && sync2_q && !i_en) begin
            state_d = ST_IDLE;
            code_d  = FLT_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Legs are held off both while leaving and while sitting in IDLE/FAULT,
    // so gates drop on the transition edge and PRECHARGE starts one edge late.
    kill = (state_q == ST_IDLE) || (state_q == ST_FAULT) ||
           (state_d == ST_IDLE) || (state_d == ST_FAULT);

    tgt_a_d = LEG_LO;
    tgt_b_d = LEG_LO;
    if (!kill && (state_q == ST_RUN)) begin
      case (pwm_q)
        CMD_POS: tgt_a_d = LEG_HI;
        CMD_NEG: tgt_b_d = LEG_HI;
        CMD_ZERO: begin
          tgt_a_d = LEG_LO;
          tgt_b_d = LEG_LO;
        end
        default: begin
          tgt_a_d = tgt_a_q;
          tgt_b_d = tgt_b_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      pwm_q    <= 2'b00;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      bad_q    <= 1'b0;
      pc_cnt_q <= '0;
      code_q   <= FLT_NONE;
      tgt_a_q  <= LEG_LO;
      tgt_b_q  <= LEG_LO;
    end else begin
      state_q  <= state_d;
      pwm_q    <= pwm_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      bad_q    <= bad_d;
      pc_cnt_q <= pc_cnt_d;
      code_q   <= code_d;
      tgt_a_q  <= tgt_a_d;
      tgt_b_q  <= tgt_b_d;
    end
  end

  leg_deadtime #(.NB_DT(NB_DT)) u_leg_a (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_kill     (kill),
    .i_target   (tgt_a_d),
    .i_deadtime (i_deadtime),
    .o_hi       (a_hi),
    .o_lo       (a_lo)
  );

  leg_deadtime #(.NB_DT(NB_DT)) u_leg_b (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_kill     (kill),
    .i_target   (tgt_b_d),
    .i_deadtime (i_deadtime),
    .o_hi       (b_hi),
    .o_lo       (b_lo)
  );

  assign o_gate[GATE_A_HI] = a_hi;
  assign o_gate[GATE_A_LO] = a_lo;
  assign o_gate[GATE_B_HI] = b_hi;
  assign o_gate[GATE_B_LO] = b_lo;
  assign o_running         = (state_q == ST_RUN);
  assign o_fault           = (state_q == ST_FAULT);
  assign o_fault_code      = code_q;

endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// tb/tb_hbridge_gate_sequencer.sv - self-checking bench for hbridge_gate_sequencer
module tb_hbridge_gate_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, en, fault_n, clr;
  logic [1:0]  pwm;
  logic [7:0]  dt;
  logic [15:0] pc;
  logic [3:0]  gate;
  logic        running, fault;
  logic [1:0]  code;

  always #5 clk = ~clk;

  hbridge_gate_sequencer #(.NB_DT(8), .NB_PC(16)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_en               (en),
    .i_pwm              (pwm),
    .i_fault_n          (fault_n),
    .i_clr_fault        (clr),
    .i_deadtime         (dt),
    .i_precharge_cycles (pc),
    .o_gate             (gate),
    .o_running          (running),
    .o_fault            (fault),
    .o_fault_code       (code)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [1:0]  pwm;
    logic        fn;
    logic        clr;
    logic [7:0]  d;
    logic [15:0] p;
    logic        chk;
    logic [3:0]  gate;
    logic        run;
    logic        flt;
    logic [1:0]  code;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: legs are tracked as "time of last retarget" plus the
  // dead time captured then; a switch is on once that much time has passed.
  localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2, M_FLT = 3;
  int         m_st, m_pwm, m_s1, m_s2, m_pre_end, m_edge;
  bit         m_bad;
  logic [1:0] m_code;
  int         m_tgt[2], m_tchg[2], m_dl[2];
  logic [3:0] m_gate;

  task automatic model_step(input logic r, input logic e, input logic [1:0] p,
                            input logic f, input logic c, input logic [7:0] d,
                            input logic [15:0] pin);
    int ost, nst, tin;
    bit ext, cmd, kill, on;
    m_edge++;
    if (!r) begin
      m_st = M_IDLE; m_pwm = 0; m_s1 = 1; m_s2 = 1; m_bad = 0; m_code = 2'b00;
      for (int i = 0; i < 2; i++) begin m_tgt[i] = 0; m_tchg[i] = -1000; m_dl[i] = 1; end
      m_gate = 4'b0000;
      return;
    end
    ost = m_st;
    nst = ost;
    ext = (m_s2 == 0);
    cmd = (ost == M_RUN) && (m_pwm == 3) && m_bad;
    if (ost != M_FLT && (ext || cmd)) begin
      nst = M_FLT;
      m_code = ext ? 2'b01 : 2'b10;
    end else if (ost == M_IDLE) begin
      if (e) begin nst = M_PRE; m_pre_end = m_edge + ((pin == 0) ? 1 : int'(pin)); end
    end else if (ost == M_PRE) begin
      if (!e) nst = M_IDLE;
      else if (m_edge == m_pre_end) nst = M_RUN;
    end else if (ost == M_RUN) begin
      if (!e) nst = M_IDLE;
    end else begin
      if (c && m_s2 == 1 && !e) begin nst = M_IDLE; m_code = 2'b00; end
    end
    kill = (ost == M_IDLE) || (ost == M_FLT) || (nst == M_IDLE) || (nst == M_FLT);
    for (int i = 0; i < 2; i++) begin
      tin = 0;
      if (ost == M_RUN) begin
        if (m_pwm == 1) tin = (i == 0) ? 1 : 0;
        else if (m_pwm == 2) tin = (i == 1) ? 1 : 0;
        else if (m_pwm == 3) tin = m_tgt[i];
      end
      if (kill) begin
        m_tgt[i] = 0; m_tchg[i] = -1000; m_dl[i] = 1; on = 0;
      end else if (tin != m_tgt[i]) begin
        m_tgt[i] = tin; m_tchg[i] = m_edge; m_dl[i] = (d == 0) ? 1 : int'(d); on = 0;
      end else begin
        on = (m_edge - m_tchg[i]) >= m_dl[i];
      end
      m_gate[3-2*i] = on && (m_tgt[i] == 1);
      m_gate[2-2*i] = on && (m_tgt[i] == 0);
    end
    m_bad = (ost == M_RUN) && (m_pwm == 3);
    m_st  = nst;
    m_pwm = int'(p);
    m_s2  = m_s1;
    m_s1  = int'(f);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", name, m_edge, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n   = v.rst_n;
    en      = v.en;
    pwm     = v.pwm;
    fault_n = v.fn;
    clr     = v.clr;
    dt      = v.d;
    pc      = v.p;
    @(posedge clk);
    model_step(v.rst_n, v.en, v.pwm, v.fn, v.clr, v.d, v.p);
    #1;
    check("model", {8'h00, gate, running, fault, code},
          {8'h00, m_gate, (m_st == M_RUN), (m_st == M_FLT), m_code});
    check("overlap", {14'h0, gate[3] & gate[2], gate[1] & gate[0]}, 16'h0000);
    if (v.chk)
      check("table", {8'h00, gate, running, fault, code}, {8'h00, v.gate, v.run, v.flt, v.code});
  endtask

  function automatic void add(input logic r, input logic e, input logic [1:0] p,
                              input logic f, input logic c, input logic [7:0] d,
                              input logic [15:0] pp, input logic [3:0] g,
                              input logic run, input logic flt, input logic [1:0] cd);
    vec_t v;
    v.rst_n = r; v.en = e; v.pwm = p; v.fn = f; v.clr = c; v.d = d; v.p = pp;
    v.chk = 1'b1; v.gate = g; v.run = run; v.flt = flt; v.code = cd;
    tbl.push_back(v);
  endfunction

  vec_t       rv;
  logic [1:0] cur_pwm;
  logic [7:0] cur_d;

  initial begin
    rst_n = 0; en = 0; pwm = 0; fault_n = 1; clr = 0; dt = 0; pc = 0;
    m_edge = 0;

    // Reset, precharge P=10, dead time D=5
    add(0, 0, 2'd0, 1, 0, 8'd5, 16'd10, 4'b0000, 0, 0, 2'd0);
    add(1, 0, 2'd1, 1, 0, 8'd5, 16'd10, 4'b0000, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd5, 16'd10, 4'b0000, 0, 0, 2'd0);
    for (int i = 0; i < 9; i++) add(1, 1, 2'd1, 1, 0, 8'd5, 16'd10, 4'b0101, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd5, 16'd10, 4'b0101, 1, 0, 2'd0);
    for (int i = 0; i < 5; i++) add(1, 1, 2'd1, 1, 0, 8'd5, 16'd10, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd5, 16'd10, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd5, 16'd10, 4'b1001, 1, 0, 2'd0);
    for (int i = 0; i < 5; i++) add(1, 1, 2'd2, 1, 0, 8'd5, 16'd10, 4'b0000, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    // Single-cycle invalid command: targets held, no fault
    add(1, 1, 2'd3, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    // Two-cycle invalid command -> FAULT code 10, clear needs i_en=0
    add(1, 1, 2'd3, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    add(1, 1, 2'd3, 1, 0, 8'd5, 16'd10, 4'b0110, 1, 0, 2'd0);
    add(1, 1, 2'd0, 1, 0, 8'd5, 16'd10, 4'b0000, 0, 1, 2'd2);
    add(1, 1, 2'd0, 1, 1, 8'd5, 16'd10, 4'b0000, 0, 1, 2'd2);
    add(1, 0, 2'd0, 1, 1, 8'd5, 16'd10, 4'b0000, 0, 0, 2'd0);
    // D=0, P=0 behave as 1; reset mid dead time
    add(1, 1, 2'd0, 1, 0, 8'd0, 16'd0, 4'b0000, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd0, 16'd0, 4'b0101, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd0, 16'd0, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd0, 16'd0, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd0, 16'd0, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd2, 1, 0, 8'd0, 16'd0, 4'b0000, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd5, 16'd0, 4'b0110, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd5, 16'd0, 4'b0000, 1, 0, 2'd0);
    add(0, 1, 2'd1, 1, 0, 8'd5, 16'd0, 4'b0000, 0, 0, 2'd0);
    add(1, 0, 2'd1, 1, 0, 8'd5, 16'd0, 4'b0000, 0, 0, 2'd0);
    // External fault pulse in RUN, clear blocked while i_en=1
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0000, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0101, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0101, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 0, 0, 8'd2, 16'd2, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0000, 0, 1, 2'd1);
    add(1, 1, 2'd1, 1, 1, 8'd2, 16'd2, 4'b0000, 0, 1, 2'd1);
    add(1, 0, 2'd1, 1, 1, 8'd2, 16'd2, 4'b0000, 0, 0, 2'd0);
    // Simultaneous external and invalid-command fault -> code 01
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0000, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0101, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0101, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd2, 16'd2, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd3, 0, 0, 8'd2, 16'd2, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd3, 1, 0, 8'd2, 16'd2, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd0, 1, 0, 8'd2, 16'd2, 4'b0000, 0, 1, 2'd1);
    add(1, 0, 2'd0, 1, 1, 8'd2, 16'd2, 4'b0000, 0, 0, 2'd0);
    // Retarget during dead time, D=8
    add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0000, 0, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0101, 1, 0, 2'd0);
    for (int i = 0; i < 8; i++) add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd0, 1, 0, 8'd8, 16'd1, 4'b1001, 1, 0, 2'd0);
    add(1, 1, 2'd0, 1, 0, 8'd8, 16'd1, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd0, 1, 0, 8'd8, 16'd1, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0001, 1, 0, 2'd0);
    for (int i = 0; i < 8; i++) add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0001, 1, 0, 2'd0);
    add(1, 1, 2'd1, 1, 0, 8'd8, 16'd1, 4'b1001, 1, 0, 2'd0);
    add(1, 0, 2'd1, 1, 0, 8'd8, 16'd1, 4'b0000, 0, 0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Randomized traffic checked against the model only
    cur_pwm = 2'd0;
    cur_d   = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      rv.chk   = 1'b0;
      rv.gate  = 4'b0000;
      rv.run   = 1'b0;
      rv.flt   = 1'b0;
      rv.code  = 2'b00;
      rv.rst_n = ($urandom_range(0, 299) != 0);
      if (m_st == M_FLT) rv.en = 1'($urandom_range(0, 1));
      else rv.en = ($urandom_range(0, 59) != 0);
      rv.clr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0)
        cur_pwm = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rv.pwm = cur_pwm;
      rv.fn  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) cur_d = 8'($urandom_range(0, 9));
      rv.d = cur_d;
      rv.p = 16'($urandom_range(0, 12));
      apply(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
